uart_rx_mon: RTL and testbench

- Parametrised, synthesizable UART receive monitor for the SoC simulation top and FPGA debug.
- Successor to the fixed 8N1 behavioural receive task in the sim bench.
- Decodes frames on one serial line with a runtime baud divisor, configurable data bits, parity and stop bits.
- Pushes received characters with per-character error flags into a first-word-fall-through FIFO, read over a valid/ready port.

---
 rtl/uart_rx_mon.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_mon.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mon.sv
// UART receive monitor: synchronised rx, runtime baud divisor, configurable frame
// format, and a first-word-fall-through FIFO of {ferr, perr, data} entries.
module uart_rx_mon #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [DIV_W-1:0]                  baud_div,
    input  logic                              rx,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic                              rd_perr,
    output logic                              rd_ferr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow,
    input  logic                              clear_ovf,
    output logic                              busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = DATA_BITS + 2;
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // ---------------- synchroniser and start-edge detect ----------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rxs;
    logic                   start_edge;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
        rxs        = sync_q[SYNC_STAGES-1];
        prev_d     = rxs;
        start_edge = prev_q & ~rxs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // ---------------- receiver FSM ----------------
    state_t               state_q, state_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     div_eff;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ferr_acc;
    logic                 expire;
    logic                 push;
    logic [EW-1:0]        push_entry;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ferr_acc   = ferr_q | ~rxs;
        push       = 1'b0;
        push_entry = {ferr_acc, perr_q, data_q};
        div_eff    = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
        expire     = (cnt_q <= DIV_W'(1));

        case (state_q)
            IDLE: begin
                if (en && start_edge) begin
                    state_d = START;
                    div_d   = div_eff;
                    cnt_d   = div_eff >> 1;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (!expire) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = div_q;
                end
            end
            DATA: begin
                if (!expire) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else begin
                    data_d = {rxs, data_q[DATA_BITS-1:1]};
                    cnt_d  = div_q;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            PAR: begin
                if (!expire) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else begin
                    // odd parity expects an overall XOR of 1, even expects 0
                    if (PARITY == 1) perr_d = ~(^data_q ^ rxs);
                    else             perr_d = ^data_q ^ rxs;
                    cnt_d   = div_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (!expire) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else if (bit_q == LAST_STOP) begin
                    // leave at mid-stop so a back-to-back start edge is caught
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    ferr_d = ferr_acc;
                    bit_d  = bit_q + 4'd1;
                    cnt_d  = div_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!en) begin
            state_d = IDLE;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_ff @(posedge clk) begin
        div_q  <= div_d;
        data_q <= data_d;
    end

    assign busy = (state_q != IDLE);

    // ---------------- FWFT FIFO and overflow flag ----------------
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;
    logic [EW-1:0] head;

    always_comb begin
        full     = (count_q == DEPTH_C);
        do_pop   = rd_valid & rd_ready;
        do_push  = push & (~full | do_pop);
        drop     = push & full & ~do_pop;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop)           ovf_d = 1'b1;
        else if (clear_ovf) ovf_d = 1'b0;
        else                ovf_d = ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    // head is gated so the data outputs read zero while the FIFO is empty
    assign head       = mem_q[rd_ptr_q];
    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? head[DATA_BITS-1:0] : '0;
    assign rd_perr    = rd_valid & head[DATA_BITS];
    assign rd_ferr    = rd_valid & head[DATA_BITS+1];
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_rx_mon.sv
// Bench for uart_rx_mon: an 8N1 instance and an 8E1 instance driven by directed
// frames; expected entries are queued at send time and checked by a monitor.
module tb_uart_rx_mon;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst_n, en, rd_ready, clear_ovf;
    logic [15:0] baud_div;
    logic        rx0, rx1;

    logic       v0, pe0, fe0, ovf0, busy0;
    logic [7:0] d0;
    logic [3:0] cnt0;
    logic       v1, pe1, fe1, ovf1, busy1;
    logic [7:0] d1;
    logic [3:0] cnt1;

    int         checks   = 0;
    int         failures = 0;
    int         lat;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] e0, e1;

    always #5 clk = ~clk;

    uart_rx_mon #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8),
                  .DIV_W(16), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .baud_div(baud_div), .rx(rx0),
        .rd_valid(v0), .rd_ready(rd_ready), .rd_data(d0), .rd_perr(pe0),
        .rd_ferr(fe0), .fifo_count(cnt0), .overflow(ovf0),
        .clear_ovf(clear_ovf), .busy(busy0));

    uart_rx_mon #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8),
                  .DIV_W(16), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .baud_div(baud_div), .rx(rx1),
        .rd_valid(v1), .rd_ready(rd_ready), .rd_data(d1), .rd_perr(pe1),
        .rd_ferr(fe1), .fifo_count(cnt1), .overflow(ovf1),
        .clear_ovf(clear_ovf), .busy(busy1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int inst, input logic v);
        if (inst == 0) rx0 = v;
        else           rx1 = v;
    endtask

    // par < 0: no parity bit; otherwise par[0] is the parity bit sent
    task automatic send_frame(input int inst, input logic [7:0] d, input int par,
                              input logic stop);
        set_rx(inst, 1'b0);
        repeat (D) tick();
        for (int i = 0; i < 8; i++) begin
            set_rx(inst, d[i]);
            repeat (D) tick();
        end
        if (par >= 0) begin
            set_rx(inst, par[0]);
            repeat (D) tick();
        end
        set_rx(inst, stop);
        repeat (D) tick();
    endtask

    // scoreboard monitor: a pop happens at the next posedge when valid & ready
    always @(negedge clk) begin
        if (rst_n && v0 && rd_ready) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut0_unexpected_entry actual=%0h expected=none", {fe0, pe0, d0});
            end else begin
                e0 = q0.pop_front();
                chk("dut0_entry", {22'd0, fe0, pe0, d0}, {22'd0, e0});
            end
        end
        if (rst_n && v1 && rd_ready) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected_entry actual=%0h expected=none", {fe1, pe1, d1});
            end else begin
                e1 = q1.pop_front();
                chk("dut1_entry", {22'd0, fe1, pe1, d1}, {22'd0, e1});
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; rd_ready = 1'b1; clear_ovf = 1'b0;
        baud_div = 16'(D); rx0 = 1'b1; rx1 = 1'b1;
        repeat (3) tick();
        chk("rst_rd_valid", 32'(v0), 0);
        chk("rst_rd_data", 32'(d0), 0);
        chk("rst_rd_perr", 32'(pe0), 0);
        chk("rst_rd_ferr", 32'(fe0), 0);
        chk("rst_fifo_count", 32'(cnt0), 0);
        chk("rst_overflow", 32'(ovf0), 0);
        chk("rst_busy", 32'(busy0), 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // 8N1 0x55 with latency bound from the falling edge
        q0.push_back({2'b00, 8'h55});
        lat = -1;
        fork
            send_frame(0, 8'h55, -1, 1'b1);
            begin
                for (int i = 1; i <= 157; i++) begin
                    tick();
                    if (v0 && lat < 0) lat = i;
                end
            end
        join
        chk("latency_0x55_seen", 32'(lat >= 0), 1);
        repeat (D) tick();

        // even parity: 0xA3 has four ones
        q1.push_back({2'b01, 8'hA3});
        send_frame(1, 8'hA3, 1, 1'b1);
        repeat (2 * D) tick();
        q1.push_back({2'b00, 8'hA3});
        send_frame(1, 8'hA3, 0, 1'b1);
        repeat (2 * D) tick();

        // framing error with the line held low afterwards
        rd_ready = 1'b0;
        q0.push_back({2'b10, 8'h7E});
        send_frame(0, 8'h7E, -1, 1'b0);
        repeat (3 * D) tick();
        chk("ferr_count_low", 32'(cnt0), 1);
        chk("ferr_head_flag", 32'(fe0), 1);
        chk("ferr_busy_low", 32'(busy0), 0);
        rx0 = 1'b1;
        repeat (2 * D) tick();
        chk("ferr_count_high", 32'(cnt0), 1);
        rd_ready = 1'b1;
        repeat (4) tick();

        // 4-cycle glitch is a false start
        rx0 = 1'b0;
        repeat (4) tick();
        chk("glitch_busy_start", 32'(busy0), 1);
        rx0 = 1'b1;
        repeat (20) tick();
        chk("glitch_busy_end", 32'(busy0), 0);
        chk("glitch_count", 32'(cnt0), 0);

        // nine back-to-back frames into an 8-entry FIFO
        rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) q0.push_back({2'b00, 8'(i)});
            send_frame(0, 8'(i), -1, 1'b1);
        end
        repeat (4) tick();
        chk("ovf_fifo_count", 32'(cnt0), 8);
        chk("ovf_flag", 32'(ovf0), 1);
        rd_ready = 1'b1;
        repeat (12) tick();
        chk("ovf_drained_count", 32'(cnt0), 0);
        chk("ovf_sticky", 32'(ovf0), 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(ovf0), 0);

        // drop en after three data bits
        rx0 = 1'b0; repeat (D) tick();
        rx0 = 1'b1; repeat (D) tick();
        rx0 = 1'b0; repeat (D) tick();
        rx0 = 1'b1; repeat (D) tick();
        chk("en_busy_mid", 32'(busy0), 1);
        en = 1'b0;
        tick();
        chk("en_busy_off", 32'(busy0), 0);
        repeat (D) tick();
        en = 1'b1;
        repeat (2 * D) tick();
        chk("en_count", 32'(cnt0), 0);

        // reset mid-frame with an entry in the FIFO
        rd_ready = 1'b0;
        send_frame(0, 8'h11, -1, 1'b1);
        repeat (4) tick();
        chk("pre_rst_count", 32'(cnt0), 1);
        rx0 = 1'b0;
        repeat (40) tick();
        chk("pre_rst_busy", 32'(busy0), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_valid", 32'(v0), 0);
        chk("mid_rst_rd_data", 32'(d0), 0);
        chk("mid_rst_count", 32'(cnt0), 0);
        chk("mid_rst_busy", 32'(busy0), 0);
        chk("mid_rst_overflow", 32'(ovf0), 0);
        rx0 = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        rd_ready = 1'b1;
        q0.push_back({2'b00, 8'h3C});
        send_frame(0, 8'h3C, -1, 1'b1);
        repeat (D) tick();

        for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) tick();
        chk("dut0_queue_drained", 32'(q0.size()), 0);
        chk("dut1_queue_drained", 32'(q1.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
